core_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for one ring-network core. It drives the PC register's advance enable (pc_go) and runs the single-outstanding request/response handshake with the I-cache. It buffers one fetched word when decode back-pressures, and squashes in-flight fetches on a decode-stage redirect. It sits between the PC register, the I-cache port and the decode stage.

---
 rtl/core_fetch_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_core_fetch_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_fetch_ctrl.sv
// core_fetch_ctrl: instruction-fetch sequencer for one ring-network core.
// Drives the PC advance enable, runs a single-outstanding I-cache
// request/response handshake, parks one word while decode stalls and
// squashes in-flight fetches on a decode-stage redirect.
// Optional build macro: IF_PERF_CNT_EN adds fetch/bubble performance counters.
//
// Handshakes: an I-cache request is accepted on a cycle with ic_req && ic_gnt;
// a response is consumed on any cycle with ic_rvalid (never back-pressured,
// at most one outstanding); decode consumes a word on if_valid && de_ready
// while redirect is low.
module core_fetch_ctrl #(
    parameter int WAIT_TIMEOUT = 255,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_en,
    input  logic [31:0]      pc,
    input  logic             redirect,
    input  logic             de_ready,
    output logic             ic_req,
    output logic [31:0]      ic_addr,
    input  logic             ic_gnt,
    input  logic             ic_rvalid,
    input  logic [31:0]      ic_rdata,
    output logic             pc_go,
    output logic             if_valid,
    output logic [31:0]      if_inst,
    output logic [31:0]      if_pc,
    output logic             ic_err,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

    // Last WAIT cycle index before the fetch is abandoned.
    localparam logic [7:0] TMO_LAST = 8'(WAIT_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] hold_q, hold_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        ic_err_q, ic_err_d;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Datapath registers: fetch address, parked word, wait counter, error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_pc_q  <= '0;
            hold_q   <= '0;
            tmo_q    <= '0;
            ic_err_q <= 1'b0;
        end else begin
            if_pc_q  <= if_pc_d;
            hold_q   <= hold_d;
            tmo_q    <= tmo_d;
            ic_err_q <= ic_err_d;
        end
    end

    // Next-state logic; redirect outranks delivery, delivery outranks timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (fetch_en) state_d = S_REQ;
            end
            S_REQ: begin
                if (ic_gnt)                     state_d = redirect ? S_DRAIN : S_WAIT;
                else if (!redirect && !fetch_en) state_d = S_IDLE;
            end
            S_WAIT: begin
                if (redirect)            state_d = ic_rvalid ? S_REQ : S_DRAIN;
                else if (ic_rvalid)      state_d = de_ready ? (fetch_en ? S_REQ : S_IDLE) : S_HOLD;
                else if (tmo_q == TMO_LAST) state_d = S_IDLE;
            end
            S_HOLD: begin
                if (redirect)      state_d = S_REQ;
                else if (de_ready) state_d = fetch_en ? S_REQ : S_IDLE;
            end
            S_DRAIN: begin
                // A redirect coinciding with the drained response restarts fetch.
                if (ic_rvalid) state_d = (redirect || fetch_en) ? S_REQ : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath-update logic per state.
    always_comb begin
        ic_req   = 1'b0;
        ic_addr  = '0;
        pc_go    = 1'b0;
        if_valid = 1'b0;
        if_inst  = '0;
        if_pc_d  = if_pc_q;
        hold_d   = hold_q;
        tmo_d    = tmo_q;
        ic_err_d = ic_err_q;
        case (state_q)
            S_REQ: begin
                ic_req  = 1'b1;
                ic_addr = pc;
                pc_go   = redirect;
                if (ic_gnt) begin
                    if_pc_d = pc;
                    tmo_d   = '0;
                end
            end
            S_WAIT: begin
                tmo_d = tmo_q + 8'd1;
                if (redirect) begin
                    pc_go = 1'b1;
                end else if (ic_rvalid) begin
                    if (de_ready) begin
                        if_valid = 1'b1;
                        if_inst  = ic_rdata;
                        pc_go    = 1'b1;
                    end else begin
                        hold_d = ic_rdata;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    ic_err_d = 1'b1;
                end
            end
            S_HOLD: begin
                if_inst = hold_q;
                if (redirect) begin
                    pc_go = 1'b1;
                end else begin
                    if_valid = 1'b1;
                    pc_go    = de_ready;
                end
            end
            S_DRAIN: begin
                pc_go = redirect;
            end
            default: begin
            end
        endcase
    end

    assign if_pc     = if_pc_q;
    assign ic_err    = ic_err_q;
    assign dbg_state = state_q;

`ifdef IF_PERF_CNT_EN
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Counter increments: delivered words and fetch-enabled empty cycles.
    always_comb begin
        fetch_cnt_d  = fetch_cnt_q + CNT_W'(if_valid && de_ready && !redirect);
        bubble_cnt_d = bubble_cnt_q + CNT_W'(fetch_en && !if_valid);
    end

    // Performance counter registers; wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_cnt  = fetch_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    assign fetch_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_core_fetch_ctrl.sv
// tb_core_fetch_ctrl: directed scenarios followed by randomized traffic,
// checked cycle by cycle against a flag-based behavioural model of the
// fetch sequencer plus a queue of expected delivered {pc, inst} pairs.
module tb_core_fetch_ctrl;

  localparam int CNT_W        = 16;
  localparam int WAIT_TIMEOUT = 255;

  logic             clk;
  logic             rst;
  logic             fetch_en;
  logic [31:0]      pc;
  logic             redirect;
  logic             de_ready;
  logic             ic_req;
  logic [31:0]      ic_addr;
  logic             ic_gnt;
  logic             ic_rvalid;
  logic [31:0]      ic_rdata;
  logic             pc_go;
  logic             if_valid;
  logic [31:0]      if_inst;
  logic [31:0]      if_pc;
  logic             ic_err;
  logic [CNT_W-1:0] fetch_cnt;
  logic [CNT_W-1:0] bubble_cnt;
  logic [2:0]       dbg_state;

  core_fetch_ctrl #(.WAIT_TIMEOUT(WAIT_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .pc(pc), .redirect(redirect),
    .de_ready(de_ready), .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt),
    .ic_rvalid(ic_rvalid), .ic_rdata(ic_rdata), .pc_go(pc_go),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .ic_err(ic_err),
    .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset block ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One flag per phase of a fetch's life; at most one is set at a time.
  bit               m_ask;     // request is being presented to the cache
  bit               m_pend;    // granted fetch whose response will be delivered
  bit               m_disc;    // granted fetch whose response will be thrown away
  bit               m_hold;    // word parked until decode takes it
  logic [31:0]      m_word;
  logic [31:0]      m_addr;
  int               m_waited;  // response cycles already spent on the pending fetch
  bit               m_err;
  logic [CNT_W-1:0] m_fetch;
  logic [CNT_W-1:0] m_bubble;

  logic [31:0] pc_r;       // PC register as seen by the fetch unit
  logic [31:0] next_tgt;   // target loaded when a redirect advances the PC
  int          go_cnt;     // observed pc_go pulses

  // Observed values from the latest step, for scenario-specific checks.
  logic        last_req, last_go, last_valid, last_err;
  logic [31:0] last_addr, last_inst, last_if_pc;
  logic [CNT_W-1:0] last_fetch, last_bubble;
  bit          g_e_req;

  task automatic model_reset();
    m_ask = 0; m_pend = 0; m_disc = 0; m_hold = 0;
    m_word = '0; m_addr = '0; m_waited = 0; m_err = 0;
    m_fetch = '0; m_bubble = '0;
  endtask

  // ---------------- driver ----------------
  // Drive one cycle of inputs, compare against the model, advance one clock.
  task automatic step(input bit r, input bit fe, input bit rd, input bit dr,
                      input bit g, input bit rv, input logic [31:0] rdat);
    bit e_req, e_go, e_valid;
    logic [31:0] e_addr, e_inst;
    bit n_ask, n_pend, n_disc, n_hold, n_err;
    logic [31:0] n_word, n_addr;
    int n_waited;
    logic [63:0] front;

    rst = r; fetch_en = fe; redirect = rd; de_ready = dr;
    ic_gnt = g; ic_rvalid = rv; ic_rdata = rdat; pc = pc_r;
    #4;

    e_req = m_ask; e_addr = m_ask ? pc_r : 32'h0;
    e_go = 0; e_valid = 0; e_inst = '0;
    n_ask = m_ask; n_pend = m_pend; n_disc = m_disc; n_hold = m_hold;
    n_word = m_word; n_addr = m_addr; n_waited = m_waited; n_err = m_err;

    if (m_ask) begin
      if (g) begin
        n_ask = 0;
        if (rd) begin e_go = 1; n_disc = 1; end
        else begin n_pend = 1; n_addr = pc_r; n_waited = 0; end
      end else if (rd) begin
        e_go = 1;
      end else if (!fe) begin
        n_ask = 0;
      end
    end else if (m_pend) begin
      n_waited = m_waited + 1;
      if (rd) begin
        e_go = 1; n_pend = 0;
        if (rv) n_ask = 1; else n_disc = 1;
      end else if (rv) begin
        n_pend = 0;
        if (dr) begin
          e_valid = 1; e_inst = rdat; e_go = 1; n_ask = fe;
        end else begin
          n_hold = 1; n_word = rdat;
        end
      end else if (m_waited + 1 == WAIT_TIMEOUT) begin
        n_err = 1; n_pend = 0;
      end
    end else if (m_hold) begin
      if (rd) begin
        e_go = 1; n_hold = 0; n_ask = 1;
      end else begin
        e_valid = 1; e_inst = m_word;
        if (dr) begin e_go = 1; n_hold = 0; n_ask = fe; end
      end
    end else if (m_disc) begin
      if (rd) e_go = 1;
      if (rv) begin n_disc = 0; n_ask = fe || rd; end
    end else begin
      if (fe) n_ask = 1;
    end

    if (e_valid && dr) exp_q.push_back({m_addr, e_inst});

    check("ic_req", ic_req, e_req);
    check("ic_addr", ic_addr, e_addr);
    check("pc_go", pc_go, e_go);
    check("if_valid", if_valid, e_valid);
    check("ic_err", ic_err, m_err);
    if (e_valid) check("if_inst", if_inst, e_inst);
`ifdef IF_PERF_CNT_EN
    check("fetch_cnt", fetch_cnt, m_fetch);
    check("bubble_cnt", bubble_cnt, m_bubble);
`else
    check("fetch_cnt", fetch_cnt, 0);
    check("bubble_cnt", bubble_cnt, 0);
`endif
    if (if_valid && de_ready && !redirect) begin
      check("sb_avail", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        front = exp_q.pop_front();
        check("sb_word", {if_pc, if_inst}, front);
      end
    end

    last_req = ic_req; last_addr = ic_addr; last_go = pc_go;
    last_valid = if_valid; last_inst = if_inst; last_if_pc = if_pc;
    last_err = ic_err; last_fetch = fetch_cnt; last_bubble = bubble_cnt;
    if (pc_go) go_cnt++;
    g_e_req = e_req;

    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (e_valid && dr && !rd) m_fetch = m_fetch + 1'b1;
      if (fe && !e_valid)       m_bubble = m_bubble + 1'b1;
      m_ask = n_ask; m_pend = n_pend; m_disc = n_disc; m_hold = n_hold;
      m_word = n_word; m_addr = n_addr; m_waited = n_waited; m_err = n_err;
    end
    if (e_go) pc_r = rd ? next_tgt : pc_r + 32'd4;
    #1;
  endtask

  // ---------------- stimulus ----------------
  bit          c_busy;
  int          c_delay;
  logic [31:0] c_word;

  initial begin
    logic [31:0] w;
    bit fe, rd, dr, g, rv;

    rst = 1; fetch_en = 0; redirect = 0; de_ready = 0;
    ic_gnt = 0; ic_rvalid = 0; ic_rdata = '0; pc = '0;
    pc_r = 32'h0004_0000; next_tgt = '0; go_cnt = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ic_req", ic_req, 0);
    check("rst_ic_addr", ic_addr, 0);
    check("rst_pc_go", pc_go, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_if_inst", if_inst, 0);
    check("rst_if_pc", if_pc, 0);
    check("rst_ic_err", ic_err, 0);
    check("rst_fetch_cnt", fetch_cnt, 0);
    check("rst_bubble_cnt", bubble_cnt, 0);

    // Plain fetch: grant at once, response two cycles later, decode ready.
    go_cnt = 0;
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 1, 0, 0);
    check("t1_addr", last_addr, 32'h0004_0000);
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 1, 32'hCAFE_0001);
    check("t1_valid", last_valid, 1);
    check("t1_if_pc", last_if_pc, 32'h0004_0000);
    check("t1_inst", last_inst, 32'hCAFE_0001);
    step(0, 0, 0, 1, 0, 0, 0);
    check("t1_go_pulses", go_cnt, 1);

    // Decode stalls: word parked, held stable, single pc_go on acceptance.
    go_cnt = 0;
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 1, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0, 0, 32'hDEAD_BEEF);
      check("t2_hold_valid", last_valid, 1);
      check("t2_hold_inst", last_inst, 32'h1234_5678);
      check("t2_hold_go", last_go, 0);
    end
    step(0, 1, 0, 1, 0, 0, 0);
    check("t2_accept_go", last_go, 1);
    step(0, 0, 0, 1, 0, 0, 0);
    check("t2_go_pulses", go_cnt, 1);

    // Redirect while waiting: response drained, new pc requested.
    next_tgt = 32'h0010_0200;
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 0, 0, 0);
    check("t3_redir_go", last_go, 1);
    step(0, 1, 0, 1, 0, 1, 32'hBAD0_BAD0);
    check("t3_drained", last_valid, 0);
    step(0, 1, 0, 1, 0, 0, 0);
    check("t3_new_req", last_req, 1);
    check("t3_new_addr", last_addr, 32'h0010_0200);
    step(0, 0, 0, 1, 0, 0, 0);

    // Redirect together with the response: word dropped, straight back to request.
    next_tgt = 32'h0020_0000;
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 0, 1, 32'h5555_AAAA);
    check("t4_valid", last_valid, 0);
    check("t4_go", last_go, 1);
    step(0, 1, 0, 1, 0, 0, 0);
    check("t4_req", last_req, 1);
    check("t4_addr", last_addr, 32'h0020_0000);
    step(0, 0, 0, 1, 0, 0, 0);

    // Response never comes: sticky timeout error.
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 1, 0, 0);
    for (int i = 0; i < WAIT_TIMEOUT; i++) step(0, 1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    check("t5_err", last_err, 1);
    check("t5_idle", last_req, 0);
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 32'h7777_7777);
    check("t5_late_rvalid", last_valid, 0);
    check("t5_err_sticky", last_err, 1);
    step(1, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    check("t5_err_cleared", last_err, 0);

    // Reset in the middle of a fetch; the late response is ignored.
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 1, 0, 0);
    step(1, 1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 32'h9999_0000);
    check("t6_ignored", last_valid, 0);

    // Ten back-to-back deliveries.
    step(1, 0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 1, 1, 0, 0);
      step(0, 1, 0, 1, 0, 1, $urandom);
    end
    step(0, 0, 0, 1, 0, 0, 0);
`ifdef IF_PERF_CNT_EN
    check("t7_fetch_cnt", last_fetch, 10);
    check("t7_bubble_cnt", last_bubble, 11);
`else
    check("t7_fetch_cnt", last_fetch, 0);
    check("t7_bubble_cnt", last_bubble, 0);
`endif

    // Randomized traffic with a bounded-latency I-cache responder.
    step(1, 0, 0, 1, 0, 0, 0);
    c_busy = 0; c_delay = 0; c_word = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      fe = ($urandom_range(0, 9) != 0);
      rd = ($urandom_range(0, 99) < 8);
      dr = ($urandom_range(0, 9) < 7);
      g  = ($urandom_range(0, 3) != 0);
      rv = c_busy && (c_delay == 0);
      w  = rv ? c_word : $urandom;
      next_tgt = $urandom & 32'hFFFF_FFFC;
      step(0, fe, rd, dr, g, rv, w);
      if (rv) c_busy = 0;
      else if (c_busy) c_delay--;
      if (g_e_req && g) begin
        c_busy = 1; c_delay = $urandom_range(0, 4); c_word = $urandom;
      end
    end

    // Wind down: stop fetching and let any outstanding fetch complete.
    for (int cyc = 0; cyc < 40; cyc++) begin
      rv = c_busy && (c_delay == 0);
      step(0, 0, 0, 1, 0, rv, c_word);
      if (rv) c_busy = 0;
      else if (c_busy) c_delay--;
    end
    check("end_idle_req", ic_req, 0);
    check("end_sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
